mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single memory request slot.
//   Port 0 carries icache miss fills and port 1 carries vector loads/stores. Read requests
//   are credit-limited per port. Memory responses are routed back to a port by the tag
//   in access_id[6:5].
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req0/req1  port requests (valid on .vld); grant0/grant1 are combinational accepts
//   mem_req    registered request slot to memory; mem_grant is the memory-side accept
//   mem_rsp    memory response (valid on .vld)
//   rsp0/rsp1  registered responses routed to each port
//   rsp_err    sticky: a response arrived for a port with no outstanding reads

package mem_arbiter_pkg;
    typedef enum logic {READ_REQ = 1'b0, WRITE_REQ = 1'b1} req_type_e;

    typedef struct packed {
        logic        vld;
        req_type_e   rtype;
        logic [6:0]  access_id;
        logic [31:0] addr;
        logic [31:0] data;
    } request_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         MAX_OUTSTANDING = 32,
    parameter logic [1:0] ICACHE_ID_TAG   = 2'b01
) (
    input  logic     clk,
    input  logic     reset,
    input  request_t req0,
    output logic     grant0,
    input  request_t req1,
    output logic     grant1,
    output request_t mem_req,
    input  logic     mem_grant,
    input  request_t mem_rsp,
    output request_t rsp0,
    output request_t rsp1,
    output logic     rsp_err
);
    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

    request_t      mem_req_q, mem_req_d;
    request_t      rsp0_q, rsp0_d, rsp1_q, rsp1_d;
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          last_q, last_d;  // 0: port 0 granted last, 1: port 1 granted last
    logic          err_q, err_d;

    logic slot_free, elig0, elig1;
    logic inc0, inc1, rsp_to0, rsp_to1, dec0, dec1;

    // The slot can take a new request when empty or when its current content leaves.
    assign slot_free = !mem_req_q.vld || mem_grant;

    assign elig0 = req0.vld && slot_free && (req0.rtype == WRITE_REQ || cnt0_q < MAX_C);
    assign elig1 = req1.vld && slot_free && (req1.rtype == WRITE_REQ || cnt1_q < MAX_C);

    // Grants are forced low while reset is asserted, so nothing is accepted and then lost.
    assign grant0 = reset && elig0 && (!elig1 || last_q);
    assign grant1 = reset && elig1 && (!elig0 || !last_q);

    assign inc0    = grant0 && req0.rtype == READ_REQ;
    assign inc1    = grant1 && req1.rtype == READ_REQ;
    assign rsp_to0 = mem_rsp.vld && mem_rsp.access_id[6:5] == ICACHE_ID_TAG;
    assign rsp_to1 = mem_rsp.vld && mem_rsp.access_id[6:5] != ICACHE_ID_TAG;
    // A response to an empty counter is flagged and never decrements below zero.
    assign dec0    = rsp_to0 && cnt0_q != '0;
    assign dec1    = rsp_to1 && cnt1_q != '0;

    always_comb begin
        mem_req_d = mem_req_q;
        last_d    = last_q;
        if (grant0) begin
            mem_req_d = req0;
            last_d    = 1'b0;
        end else if (grant1) begin
            mem_req_d = req1;
            last_d    = 1'b1;
        end else if (slot_free) begin
            mem_req_d = '0;
        end

        cnt0_d = cnt0_q;
        if (inc0 && !dec0)      cnt0_d = cnt0_q + 1'b1;
        else if (dec0 && !inc0) cnt0_d = cnt0_q - 1'b1;

        cnt1_d = cnt1_q;
        if (inc1 && !dec1)      cnt1_d = cnt1_q + 1'b1;
        else if (dec1 && !inc1) cnt1_d = cnt1_q - 1'b1;

        err_d = err_q || (rsp_to0 && cnt0_q == '0) || (rsp_to1 && cnt1_q == '0);

        rsp0_d = rsp_to0 ? mem_rsp : '0;
        rsp1_d = rsp_to1 ? mem_rsp : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req_q <= '0;
            rsp0_q    <= '0;
            rsp1_q    <= '0;
            cnt0_q    <= '0;
            cnt1_q    <= '0;
            last_q    <= 1'b1;  // first contested grant goes to port 0
            err_q     <= 1'b0;
        end else begin
            mem_req_q <= mem_req_d;
            rsp0_q    <= rsp0_d;
            rsp1_q    <= rsp1_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    assign mem_req = mem_req_q;
    assign rsp0    = rsp0_q;
    assign rsp1    = rsp1_q;
    assign rsp_err = err_q;

endmodule
